// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// The slave modport is the generator; the master modport is its upstream/downstream environment.
interface window_gen_3x3_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [9*DATA_W-1:0]   out_window;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_window, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_window, frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 windows: two IMG_W-deep line buffers feed the right column of a
// 3x3 shift array; a one-entry output register holds each window until downstream takes it.
module window_gen_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic            clk,
  input  logic            reset,
  window_gen_3x3_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic                acc;
  logic                emit;
  logic                last_pix;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   win     [3][3];
  logic [DATA_W-1:0]   win_nxt [3][3];
  logic [9*DATA_W-1:0] win_packed;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign emit         = acc && (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix     = acc && (row == ROW_LAST) && (col == COL_LAST);

  // Next window: every row shifts left, the new right column is (two rows up, one row up, current).
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb0[IMG_W-1];
    win_nxt[1][2] = lb1[IMG_W-1];
    win_nxt[2][2] = bus.in_data;
    win_packed = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_packed[DATA_W*(3*r+c) +: DATA_W] = win_nxt[r][c];
      end
    end
  end

  // Line buffers hold no reset: emits are gated until two full rows have been refilled.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[0] <= bus.in_data;
      lb0[0] <= lb1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1[i] <= lb1[i-1];
        lb0[i] <= lb0[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col            <= '0;
      row            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_window <= '0;
      bus.frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      bus.frame_done <= last_pix;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win[r][c] <= win_nxt[r][c];
          end
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A fresh emit wins over a consume, so a same-cycle consume+emit keeps out_valid high.
      if (emit) begin
        bus.out_window <= win_packed;
        bus.out_valid  <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised self-checking bench for window_gen_3x3 on a 4x4 image, compared every cycle
// against an image-array model of the output register, plus literal window checks.
module tb_window_gen_3x3;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int WW     = 9 * DATA_W;

  typedef logic [DATA_W-1:0] win9_t [9];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_W(DATA_W)) bus ();

  window_gen_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int fd_count = 0;
  int acc_count = 0;
  int vpct = 0;
  int rpct = 100;
  int hold = 0;
  logic rst_req = 1'b1;
  logic bp_arm = 1'b0;
  logic in_hold = 1'b0;

  // Model state: where the next accepted pixel lands, the image so far, and the output register.
  int prow = 0;
  int pcol = 0;
  int pframe = 0;
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  logic          m_valid = 1'b0;
  logic [WW-1:0] m_window = '0;
  logic          m_done = 1'b0;
  logic [WW-1:0] got [$];
  logic [WW-1:0] mexp [$];

  win9_t f0_w0 = '{16'h00, 16'h01, 16'h02, 16'h10, 16'h11, 16'h12, 16'h20, 16'h21, 16'h22};
  win9_t f0_w1 = '{16'h01, 16'h02, 16'h03, 16'h11, 16'h12, 16'h13, 16'h21, 16'h22, 16'h23};
  win9_t f0_w2 = '{16'h10, 16'h11, 16'h12, 16'h20, 16'h21, 16'h22, 16'h30, 16'h31, 16'h32};
  win9_t f0_w3 = '{16'h11, 16'h12, 16'h13, 16'h21, 16'h22, 16'h23, 16'h31, 16'h32, 16'h33};
  win9_t f1_w0 = '{16'h100, 16'h101, 16'h102, 16'h110, 16'h111, 16'h112, 16'h120, 16'h121, 16'h122};
  win9_t f1_w3 = '{16'h111, 16'h112, 16'h113, 16'h121, 16'h122, 16'h123, 16'h131, 16'h132, 16'h133};

  function automatic logic [WW-1:0] pack9(input win9_t e);
    logic [WW-1:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[DATA_W*k +: DATA_W] = e[k];
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] pixel(input int f, input int r, input int c);
    return DATA_W'(f * 256 + r * 16 + c);
  endfunction

  task automatic checkEq(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkEq("out_valid", WW'(bus.out_valid), WW'(m_valid));
    checkEq("out_window", bus.out_window, m_window);
    checkEq("frame_done", WW'(bus.frame_done), WW'(m_done));
    checkEq("in_ready", WW'(bus.in_ready), WW'(!m_valid || bus.out_ready));
    if (in_hold) begin
      checkEq("bp_hold_in_ready", WW'(bus.in_ready), WW'(1'b0));
      checkEq("bp_hold_window", bus.out_window, pack9(f0_w0));
    end
    if (bus.frame_done) fd_count++;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_window);
  endtask

  // Predict the effect of the coming clock edge from the inputs now on the bus.
  task automatic modelUpdate();
    logic macc;
    macc = bus.in_valid && (!m_valid || bus.out_ready);
    if (reset) begin
      m_valid = 1'b0;
      m_window = '0;
      m_done = 1'b0;
      prow = 0;
      pcol = 0;
      pframe = 0;
    end else begin
      m_done = 1'b0;
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (macc) begin
        acc_count++;
        img[prow][pcol] = bus.in_data;
        if (prow >= 2 && pcol >= 2) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              m_window[DATA_W*(3*r+c) +: DATA_W] = img[prow-2+r][pcol-2+c];
          m_valid = 1'b1;
          mexp.push_back(m_window);
        end
        if (prow == IMG_H-1 && pcol == IMG_W-1) m_done = 1'b1;
        pcol++;
        if (pcol == IMG_W) begin
          pcol = 0;
          prow++;
          if (prow == IMG_H) begin
            prow = 0;
            pframe++;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reset = rst_req;
    if (bp_arm && m_valid) begin
      hold = 5;
      bp_arm = 1'b0;
    end
    in_hold = (hold > 0);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      hold--;
    end else begin
      bus.out_ready = ($urandom_range(99) < rpct);
    end
    bus.in_valid = ($urandom_range(99) < vpct);
    bus.in_data = bus.in_valid ? pixel(pframe, prow, pcol) : DATA_W'($urandom);
    @(negedge clk);
    checkOutput();
    modelUpdate();
  endtask

  task automatic runAccepts(input int n, input int budget, input string name);
    int target;
    int cyc;
    target = acc_count + n;
    cyc = 0;
    while (acc_count < target && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    tests++;
    if (acc_count < target) begin
      fails++;
      $display("[TB] FAIL %s timeout: accepted %0d, expected %0d", name, acc_count, target);
    end
  endtask

  task automatic drain(input int n);
    vpct = 0;
    rpct = 100;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic resetDut();
    rst_req = 1'b1;
    vpct = 0;
    applyStimulus();
    rst_req = 1'b0;
    applyStimulus();
  endtask

  task automatic clearLogs();
    got.delete();
    mexp.delete();
    fd_count = 0;
  endtask

  task automatic checkFrame0(input int base, input string tag);
    if (got.size() >= base + 4) begin
      checkEq({tag, "_w0"}, got[base],   pack9(f0_w0));
      checkEq({tag, "_w1"}, got[base+1], pack9(f0_w1));
      checkEq({tag, "_w2"}, got[base+2], pack9(f0_w2));
      checkEq({tag, "_w3"}, got[base+3], pack9(f0_w3));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;

    resetDut();
    checkEq("reset_out_valid", WW'(bus.out_valid), '0);
    checkEq("reset_out_window", bus.out_window, '0);
    checkEq("reset_frame_done", WW'(bus.frame_done), '0);
    checkEq("reset_in_ready", WW'(bus.in_ready), WW'(1'b1));

    // Two frames streamed back-to-back.
    clearLogs();
    vpct = 100;
    rpct = 100;
    runAccepts(2 * IMG_W * IMG_H, 200, "stream");
    drain(3);
    checkEq("stream_count", WW'(got.size()), WW'(8));
    checkEq("stream_frame_done", WW'(fd_count), WW'(2));
    if (mexp.size() > 0) checkEq("model_pin_first", mexp[0], pack9(f0_w0));
    checkFrame0(0, "stream");
    if (got.size() >= 8) begin
      checkEq("stream_f1_first", got[4], pack9(f1_w0));
      checkEq("stream_f1_last", got[7], pack9(f1_w3));
    end

    // Back-pressure for 5 cycles right after the first window.
    resetDut();
    clearLogs();
    bp_arm = 1'b1;
    vpct = 100;
    rpct = 100;
    runAccepts(IMG_W * IMG_H, 100, "backpressure");
    drain(3);
    checkEq("bp_count", WW'(got.size()), WW'(4));
    checkEq("bp_frame_done", WW'(fd_count), WW'(1));
    checkFrame0(0, "bp");

    // Random bubbles and random downstream stalls over three frames.
    resetDut();
    clearLogs();
    vpct = 50;
    rpct = 50;
    runAccepts(3 * IMG_W * IMG_H, 3000, "random");
    drain(4);
    checkEq("random_count", WW'(got.size()), WW'(12));
    checkEq("random_frame_done", WW'(fd_count), WW'(3));
    checkFrame0(0, "random");
    if (got.size() >= 8) checkEq("random_f1_first", got[4], pack9(f1_w0));

    // Reset right after pixel (2,1), while out_window still holds the previous frame's last window.
    vpct = 100;
    rpct = 100;
    runAccepts(2 * IMG_W + 2, 50, "midframe");
    rst_req = 1'b1;
    vpct = 0;
    applyStimulus();
    rst_req = 1'b0;
    applyStimulus();
    checkEq("midreset_out_valid", WW'(bus.out_valid), '0);
    checkEq("midreset_out_window", bus.out_window, '0);
    clearLogs();
    vpct = 100;
    runAccepts(IMG_W * IMG_H, 100, "refill");
    drain(3);
    checkEq("refill_count", WW'(got.size()), WW'(4));
    checkFrame0(0, "refill");

    // Reset while a window is stalled downstream.
    vpct = 100;
    rpct = 0;
    for (int i = 0; i < 60 && !m_valid; i++) applyStimulus();
    checkEq("stall_reached", WW'(m_valid), WW'(1'b1));
    rst_req = 1'b1;
    vpct = 0;
    applyStimulus();
    rst_req = 1'b0;
    applyStimulus();
    checkEq("stallreset_out_valid", WW'(bus.out_valid), '0);
    checkEq("stallreset_in_ready", WW'(bus.in_ready), WW'(1'b1));
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
